// File: rtl/pwm_ref_gen.sv
// Programmable periodic reference-pulse generator: one shared period counter drives N_CH
// level-pulse lanes, with valid/ready shadow configuration applied at period wrap.
module pwm_ref_gen #(
    parameter int CNT_W      = 2,
    parameter int OUT_W      = 5,
    parameter int N_CH       = 2,
    parameter int DEF_PERIOD = 3,
    parameter int DEF_LEVEL  = 6
) (
    input  logic                    clk,
    input  logic                    reset_central,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [N_CH*OUT_W-1:0]   cfg_level,
    input  logic [N_CH*CNT_W-1:0]   cfg_phase,
    input  logic [7:0]              cfg_burst,
    output logic [N_CH*OUT_W-1:0]   pwm_ref,
    output logic                    period_tick,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [OUT_W-1:0] DEF_L = OUT_W'(DEF_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0]      period;
        logic [N_CH*OUT_W-1:0] level;
        logic [N_CH*CNT_W-1:0] phase;
        logic [7:0]            burst;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        period: DEF_P,
        level:  {N_CH{DEF_L}},
        phase:  {N_CH{DEF_P}},
        burst:  8'd0
    };

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [7:0]            burst_cnt;
    cfg_t                  act_cfg;
    cfg_t                  shadow_cfg;
    logic                  pending;
    logic [N_CH*OUT_W-1:0] lane_next;
    logic                  wrap;
    logic                  burst_last;
    logic                  apply_cfg;

    assign wrap       = (cnt == act_cfg.period);
    assign burst_last = (act_cfg.burst != 8'd0) && ((burst_cnt + 8'd1) == act_cfg.burst);
    // Outside RUN there is no period in flight, so a pending update may land immediately.
    assign apply_cfg  = pending && ((state != S_RUN) || wrap);
    assign cfg_ready  = ~pending;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        lane_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt == act_cfg.phase[i*CNT_W +: CNT_W]) begin
                lane_next[i*OUT_W +: OUT_W] = act_cfg.level[i*OUT_W +: OUT_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_central) begin
            state       <= S_IDLE;
            cnt         <= '0;
            burst_cnt   <= 8'd0;
            pwm_ref     <= '0;
            period_tick <= 1'b0;
            busy        <= 1'b0;
            pending     <= 1'b0;
            act_cfg     <= CFG_RESET;
        end else begin
            // Capture and apply never coincide: capture needs pending low, apply needs it high.
            if (cfg_valid && !pending) begin
                pending <= 1'b1;
            end else if (apply_cfg) begin
                pending <= 1'b0;
                act_cfg <= shadow_cfg;
            end

            case (state)
                S_IDLE: begin
                    cnt         <= '0;
                    pwm_ref     <= '0;
                    period_tick <= 1'b0;
                    if (enable) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        burst_cnt <= 8'd0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt         <= wrap ? '0 : cnt + CNT_W'(1);
                    pwm_ref     <= lane_next;
                    period_tick <= wrap;
                    if (wrap) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else if (!enable) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    cnt         <= '0;
                    pwm_ref     <= '0;
                    period_tick <= 1'b0;
                    busy        <= 1'b0;
                    if (!enable) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the shadow slot carries no reset; its contents are ignored until pending is set again.
    always_ff @(posedge clk) begin
        if (cfg_valid && !pending) begin
            shadow_cfg <= '{period: cfg_period, level: cfg_level, phase: cfg_phase, burst: cfg_burst};
        end
    end

endmodule

// File: tb/tb_pwm_ref_gen.sv
// Self-checking bench for pwm_ref_gen: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of periods, bursts and the config slot.
module tb_pwm_ref_gen;

    logic       clk;
    logic       reset_central;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_period;
    logic [9:0] cfg_level;
    logic [3:0] cfg_phase;
    logic [7:0] cfg_burst;
    logic [9:0] pwm_ref;
    logic       period_tick;
    logic       busy;

    int n_run  = 0;
    int n_fail = 0;

    pwm_ref_gen dut (
        .clk           (clk),
        .reset_central (reset_central),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_level     (cfg_level),
        .cfg_phase     (cfg_phase),
        .cfg_burst     (cfg_burst),
        .pwm_ref       (pwm_ref),
        .period_tick   (period_tick),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the current period, completed-period count,
    // operating mode, and the active/offered configuration.
    typedef struct packed {
        logic [1:0] period;
        logic [9:0] level;
        logic [3:0] phase;
        logic [7:0] burst;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{period: 2'd3, level: {5'd6, 5'd6}, phase: 4'b1111, burst: 8'd0};
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_DONE = 2;

    cfg_t       m_act;
    cfg_t       m_shd;
    int         m_mode;
    int         m_pos;
    int         m_periods;
    bit         m_pend;
    logic [9:0] e_ref;
    bit         e_tick;
    bit         e_busy;

    function automatic logic [12:0] expected();
        return {e_ref, e_tick, e_busy, ~m_pend};
    endfunction

    task automatic model_update();
        int  prev_mode;
        bit  period_end;
        bit  offered;
        if (reset_central) begin
            m_mode = MODE_IDLE; m_pos = 0; m_periods = 0; m_pend = 0;
            m_act = CFG_DEFAULT; e_ref = '0; e_tick = 0; e_busy = 0;
        end else begin
            prev_mode  = m_mode;
            period_end = (m_mode == MODE_RUN) && (m_pos == int'(m_act.period));
            offered    = cfg_valid && !m_pend;
            e_ref  = '0;
            e_tick = 0;
            if (m_mode == MODE_RUN) begin
                for (int ch = 0; ch < 2; ch++)
                    if (m_pos == int'(m_act.phase[ch*2 +: 2])) e_ref[ch*5 +: 5] = m_act.level[ch*5 +: 5];
                e_tick = period_end;
            end
            case (m_mode)
                MODE_IDLE: if (enable) begin m_mode = MODE_RUN; m_pos = 0; m_periods = 0; end
                MODE_RUN: begin
                    if (period_end) begin
                        m_pos = 0;
                        m_periods = (m_periods + 1) % 256;
                        if (m_act.burst != 0 && m_periods == int'(m_act.burst)) m_mode = MODE_DONE;
                        else if (!enable) m_mode = MODE_IDLE;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end
                default: if (!enable) m_mode = MODE_IDLE;
            endcase
            e_busy = (m_mode == MODE_RUN);
            if (m_pend && (prev_mode != MODE_RUN || period_end)) begin m_act = m_shd; m_pend = 0; end
            if (offered) begin
                m_shd  = '{period: cfg_period, level: cfg_level, phase: cfg_phase, burst: cfg_burst};
                m_pend = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_cfg(input int per, input int l0, input int l1, input int p0, input int p1, input int bst);
        cfg_period = 2'(per);
        cfg_level  = {5'(l1), 5'(l0)};
        cfg_phase  = {2'(p1), 2'(p0)};
        cfg_burst  = 8'(bst);
    endtask

    task automatic do_reset();
        reset_central = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        step(); step();
        reset_central = 1'b0;
    endtask

    task automatic test_reset();
        reset_central = 1'b1; enable = 1'b1; cfg_valid = 1'b1;
        set_cfg(1, 17, 17, 0, 0, 2);
        step(); step();
        n_run++;
        if ({pwm_ref, period_tick, busy, cfg_ready} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got ref=%h tick=%b busy=%b rdy=%b exp ref=000 tick=0 busy=0 rdy=1",
                     pwm_ref, period_tick, busy, cfg_ready);
        end
        reset_central = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        step();
        n_run++;
        if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
            n_fail++;
            $display("FAIL reset_idle got %h exp %h", {pwm_ref, period_tick, busy, cfg_ready}, expected());
        end
    endtask

    // Twelve RUN edges at default config: three coincident level-6 pulses and ticks.
    task automatic test_default(input string name);
        int coincide = 0;
        int ticks    = 0;
        enable = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL %s cyc%0d got %h exp %h", name, c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
            if (c > 0 && period_tick) ticks++;
            if (c > 0 && period_tick && pwm_ref == {5'd6, 5'd6}) coincide++;
        end
        n_run++;
        if (coincide !== 3 || ticks !== 3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pulses got pulses=%0d ticks=%0d busy=%b exp 3 3 1", name, coincide, ticks, busy);
        end
    endtask

    task automatic test_cfg_update();
        int seen17 = 0;
        step();
        set_cfg(3, 17, 6, 1, 3, 0);
        for (int c = 0; c < 16; c++) begin
            cfg_valid = (c == 0);
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL cfg_update cyc%0d got %h exp %h", c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
            if (c == 0) begin
                n_run++;
                if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_ready_drop got %b exp 0", cfg_ready); end
            end
            if (pwm_ref[4:0] == 5'd17 && !period_tick) seen17++;
        end
        n_run++;
        if (seen17 < 2 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_update_applied got lane0_17=%0d rdy=%b exp >=2 1", seen17, cfg_ready);
        end
    endtask

    task automatic go_idle();
        int waited = 0;
        enable = 1'b0; cfg_valid = 1'b0;
        while (waited < 12 && (busy || m_mode != MODE_IDLE)) begin
            step();
            waited++;
        end
        n_run++;
        if (busy !== 1'b0 || m_mode != MODE_IDLE) begin
            n_fail++;
            $display("FAIL go_idle timeout got busy=%b exp 0", busy);
        end
    endtask

    task automatic load_idle(input int per, input int l0, input int l1, input int p0, input int p1, input int bst);
        set_cfg(per, l0, l1, p0, p1, bst);
        cfg_valid = 1'b1; step();
        cfg_valid = 1'b0; step();
        n_run++;
        if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
            n_fail++;
            $display("FAIL load_idle got %h exp %h", {pwm_ref, period_tick, busy, cfg_ready}, expected());
        end
    endtask

    task automatic test_burst();
        go_idle();
        load_idle(3, 9, 6, 0, 3, 3);
        for (int r = 0; r < 2; r++) begin
            int ticks = 0;
            int p0 = 0;
            int p1 = 0;
            enable = 1'b1;
            for (int c = 0; c < 20; c++) begin
                step();
                n_run++;
                if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                    n_fail++;
                    $display("FAIL burst r%0d cyc%0d got %h exp %h", r, c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
                end
                if (period_tick) ticks++;
                if (pwm_ref[4:0] == 5'd9) p0++;
                if (pwm_ref[9:5] == 5'd6) p1++;
            end
            n_run++;
            if (ticks !== 3 || p0 !== 3 || p1 !== 3 || busy !== 1'b0 || pwm_ref !== 10'd0) begin
                n_fail++;
                $display("FAIL burst_count r%0d got ticks=%0d p0=%0d p1=%0d busy=%b ref=%h exp 3 3 3 0 000",
                         r, ticks, p0, p1, busy, pwm_ref);
            end
            enable = 1'b0;
            step();
        end
    endtask

    task automatic test_short_period();
        int lane1_hits = 0;
        int lane0_hits = 0;
        int ticks      = 0;
        int constant   = 0;
        go_idle();
        load_idle(1, 11, 7, 0, 3, 0);
        enable = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL period1 cyc%0d got %h exp %h", c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
            if (pwm_ref[9:5] != 5'd0) lane1_hits++;
            if (pwm_ref[4:0] == 5'd11) lane0_hits++;
            if (period_tick) ticks++;
        end
        n_run++;
        if (lane1_hits !== 0 || lane0_hits !== 6 || ticks !== 6) begin
            n_fail++;
            $display("FAIL period1_counts got l1=%0d l0=%0d ticks=%0d exp 0 6 6", lane1_hits, lane0_hits, ticks);
        end
        set_cfg(0, 21, 7, 0, 3, 0);
        for (int c = 0; c < 12; c++) begin
            cfg_valid = (c == 0);
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL period0 cyc%0d got %h exp %h", c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
            if (c >= 4 && pwm_ref == {5'd0, 5'd21} && period_tick) constant++;
        end
        n_run++;
        if (constant !== 8) begin
            n_fail++;
            $display("FAIL period0_constant got %0d exp 8", constant);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            enable = (c < 2);
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL enable_drop cyc%0d got %h exp %h", c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
            if (c == 4) begin
                n_run++;
                if ({pwm_ref, period_tick, busy} !== {10'b00110_00110, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL enable_drop_last got ref=%h tick=%b busy=%b exp 0c6 1 0", pwm_ref, period_tick, busy);
                end
            end
            if (c == 5) begin
                n_run++;
                if ({pwm_ref, period_tick, busy} !== {10'd0, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL enable_drop_idle got ref=%h tick=%b busy=%b exp 000 0 0", pwm_ref, period_tick, busy);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        enable = 1'b1;
        set_cfg(1, 20, 20, 0, 0, 2);
        for (int c = 0; c < 3; c++) begin
            cfg_valid = (c == 1);
            step();
        end
        cfg_valid = 1'b0;
        n_run++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL pending_before_reset got rdy=%b exp 0", cfg_ready); end
        reset_central = 1'b1;
        step();
        n_run++;
        if ({pwm_ref, busy, cfg_ready} !== {10'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_pending got ref=%h busy=%b rdy=%b exp 000 0 1", pwm_ref, busy, cfg_ready);
        end
        reset_central = 1'b0;
        test_default("after_reset");
    endtask

    task automatic test_random();
        enable = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            reset_central = ($urandom_range(0, 199) == 0);
            cfg_valid     = ($urandom_range(0, 5) == 0);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
            step();
            n_run++;
            if ({pwm_ref, period_tick, busy, cfg_ready} !== expected()) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h exp %h", c, {pwm_ref, period_tick, busy, cfg_ready}, expected());
            end
        end
        reset_central = 1'b0;
    endtask

    initial begin
        reset_central = 1'b1;
        enable        = 1'b0;
        cfg_valid     = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        test_reset();
        test_default("default_run");
        test_cfg_update();
        test_burst();
        test_short_period();
        test_enable_drop();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
